// File: rtl/multistep_ro.sv
// multistep_ro: two-step (coarse/fine) time-to-digital converter.
// The fine step is a 2*NSTAGE-phase Johnson ring that advances every clk.
// The coarse step counts completed ring laps.
// The start and stop paths have equal synchroniser latency, so that latency
// cancels out of the result.
// Optional feature: define MULTISTEP_RO_OVF_EN to add the 'ovf' saturation flag.
module multistep_ro #(
  parameter int SYNC_STAGES = 2,
  parameter int NSTAGE      = 3,
  parameter int W           = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         stop,
  output logic [W-1:0] A,
  output logic         valid
`ifdef MULTISTEP_RO_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int PHASES = 2 * NSTAGE;
  localparam int TW     = W + 8;
  localparam logic [TW-1:0] MAX_COUNT = TW'((1 << W) - 1);
  localparam logic [NSTAGE-1:0] RING_LAST = {{(NSTAGE-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Johnson ring pattern to phase index 0..PHASES-1
  function automatic logic [TW-1:0] phase_decode(input logic [NSTAGE-1:0] ring);
    logic [TW-1:0] ones;
    ones = {TW{1'b0}};
    for (int i = 0; i < NSTAGE; i++) begin
      ones = ones + TW'(ring[i]);
    end
    if (ring[NSTAGE-1]) begin
      return ones;
    end else if (ones == {TW{1'b0}}) begin
      return {TW{1'b0}};
    end else begin
      return TW'(PHASES) - ones;
    end
  endfunction

  logic [SYNC_STAGES-1:0] start_sync_r;
  logic [SYNC_STAGES-1:0] stop_sync_r;
  logic                   start_prev_r;
  logic                   stop_prev_r;
  logic                   start_now_s;
  logic                   stop_now_s;
  logic                   start_edge_s;
  logic                   stop_edge_s;

  state_t                 state_r;
  state_t                 state_s;
  logic [NSTAGE-1:0]      ring_r;
  logic [NSTAGE-1:0]      ring_s;
  logic [TW-1:0]          coarse_r;
  logic [TW-1:0]          coarse_s;
  logic [W-1:0]           a_r;
  logic [W-1:0]           a_s;
  logic                   valid_r;
  logic                   valid_s;
  logic [TW-1:0]          total_s;
`ifdef MULTISTEP_RO_OVF_EN
  logic                   ovf_r;
  logic                   ovf_s;
`endif

  assign start_now_s  = start_sync_r[SYNC_STAGES-1];
  assign stop_now_s   = stop_sync_r[SYNC_STAGES-1];
  assign start_edge_s = start_now_s & ~start_prev_r;
  assign stop_edge_s  = stop_now_s & ~stop_prev_r;
  assign total_s      = (coarse_r * TW'(PHASES)) + phase_decode(ring_r);

  // Synchronise the asynchronous start/stop levels and keep their previous value for edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start_sync_r <= {SYNC_STAGES{1'b0}};
      stop_sync_r  <= {SYNC_STAGES{1'b0}};
      start_prev_r <= 1'b0;
      stop_prev_r  <= 1'b0;
    end else begin
      start_sync_r <= {start_sync_r[SYNC_STAGES-2:0], start};
      stop_sync_r  <= {stop_sync_r[SYNC_STAGES-2:0], stop};
      start_prev_r <= start_now_s;
      stop_prev_r  <= stop_now_s;
    end
  end

  // State, ring, lap counter and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      ring_r   <= {NSTAGE{1'b0}};
      coarse_r <= {TW{1'b0}};
      a_r      <= {W{1'b0}};
      valid_r  <= 1'b0;
`ifdef MULTISTEP_RO_OVF_EN
      ovf_r    <= 1'b0;
`endif
    end else begin
      state_r  <= state_s;
      ring_r   <= ring_s;
      coarse_r <= coarse_s;
      a_r      <= a_s;
      valid_r  <= valid_s;
`ifdef MULTISTEP_RO_OVF_EN
      ovf_r    <= ovf_s;
`endif
    end
  end

  // Next-state logic: arm on start, advance ring/laps while running, latch result on stop
  always_comb begin
    state_s  = state_r;
    ring_s   = ring_r;
    coarse_s = coarse_r;
    a_s      = a_r;
    valid_s  = valid_r;
`ifdef MULTISTEP_RO_OVF_EN
    ovf_s    = ovf_r;
`endif
    case (state_r)
      IDLE: begin
        if (start_edge_s) begin
          ring_s   = {NSTAGE{1'b0}};
          coarse_s = {TW{1'b0}};
          if (stop_edge_s) begin
            // Coincident edges: zero-length interval
            state_s = DONE;
            a_s     = {W{1'b0}};
            valid_s = 1'b1;
`ifdef MULTISTEP_RO_OVF_EN
            ovf_s   = 1'b0;
`endif
          end else begin
            state_s = RUN;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (stop_edge_s) begin
          // The stop-edge cycle itself is counted, hence total+1
          state_s = DONE;
          valid_s = 1'b1;
          if (total_s == MAX_COUNT) begin
            a_s   = W'(MAX_COUNT);
`ifdef MULTISTEP_RO_OVF_EN
            ovf_s = 1'b1;
`endif
          end else begin
            a_s   = W'(total_s + {{(TW-1){1'b0}}, 1'b1});
`ifdef MULTISTEP_RO_OVF_EN
            ovf_s = 1'b0;
`endif
          end
        end else if (total_s != MAX_COUNT) begin
          state_s = RUN;
          ring_s  = {~ring_r[0], ring_r[NSTAGE-1:1]};
          if (ring_r == RING_LAST) begin
            coarse_s = coarse_r + {{(TW-1){1'b0}}, 1'b1};
          end else begin
            coarse_s = coarse_r;
          end
        end else begin
          // Saturated: counting frozen until stop arrives
          state_s = RUN;
        end
      end
      DONE: begin
        if (!start_now_s && !stop_now_s) begin
          state_s = IDLE;
          valid_s = 1'b0;
`ifdef MULTISTEP_RO_OVF_EN
          ovf_s   = 1'b0;
`endif
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
        valid_s = 1'b0;
`ifdef MULTISTEP_RO_OVF_EN
        ovf_s   = 1'b0;
`endif
      end
    endcase
  end

  assign A     = a_r;
  assign valid = valid_r;
`ifdef MULTISTEP_RO_OVF_EN
  assign ovf   = ovf_r;
`endif

endmodule

// File: tb/tb_multistep_ro.sv
// Bench for multistep_ro: the reference result is min(stop-start interval in clk cycles, 63).
module tb_multistep_ro;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic [5:0] a;
  logic       valid;
`ifdef MULTISTEP_RO_OVF_EN
  logic       ovf;
`endif

  int vectors;
  int miscompares;
  int last_a;

  multistep_ro #(.SYNC_STAGES(2), .NSTAGE(3), .W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .stop  (stop),
    .A     (a),
    .valid (valid)
`ifdef MULTISTEP_RO_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (a !== 6'd0 || valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: A=%0d valid=%b, expected A=0 valid=0", a, valid);
    end
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    last_a = 0;
  endtask

  // One start/stop measurement d cycles apart, result held for 'hold' cycles, then release
  task automatic measure(input int d, input int hold);
    int  exp_a;
    bit  got;
    exp_a = (d > 63) ? 63 : d;
    @(posedge clk);
    #1 start = 1'b1;
    if (d == 0) begin
      stop = 1'b1;
    end else begin
      repeat (d) @(posedge clk);
      #1;
      vectors++;
      if (valid !== 1'b0) begin
        miscompares++;
        $display("FAIL early_valid d=%0d: valid=%b, expected 0", d, valid);
      end
      stop = 1'b1;
    end
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      if (valid === 1'b1) got = 1'b1;
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL valid_timeout d=%0d: valid=%b, expected 1 within 12 cycles", d, valid);
    end
    vectors++;
    if (a !== 6'(exp_a)) begin
      miscompares++;
      $display("FAIL result d=%0d: A=%0d, expected %0d", d, a, exp_a);
    end
`ifdef MULTISTEP_RO_OVF_EN
    vectors++;
    if (ovf !== (d > 63)) begin
      miscompares++;
      $display("FAIL ovf d=%0d: ovf=%b, expected %b", d, ovf, (d > 63));
    end
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      vectors++;
      if (a !== 6'(exp_a) || valid !== 1'b1) begin
        miscompares++;
        $display("FAIL hold d=%0d cyc=%0d: A=%0d valid=%b, expected A=%0d valid=1", d, i, a, valid, exp_a);
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    repeat (6) @(negedge clk);
    vectors++;
    if (valid !== 1'b0 || a !== 6'(exp_a)) begin
      miscompares++;
      $display("FAIL release d=%0d: A=%0d valid=%b, expected A=%0d valid=0", d, a, valid, exp_a);
    end
`ifdef MULTISTEP_RO_OVF_EN
    vectors++;
    if (ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_clear d=%0d: ovf=%b, expected 0", d, ovf);
    end
`endif
    last_a = exp_a;
  endtask

  task automatic test_basic();
    measure(3, 22);
    measure(13, 2);
  endtask

  task automatic test_same_cycle();
    measure(0, 3);
  endtask

  task automatic test_stop_idle();
    @(posedge clk);
    #1 stop = 1'b1;
    repeat (2) @(posedge clk);
    #1 stop = 1'b0;
    repeat (6) @(negedge clk);
    vectors++;
    if (valid !== 1'b0 || a !== 6'(last_a)) begin
      miscompares++;
      $display("FAIL stop_idle: A=%0d valid=%b, expected A=%0d valid=0", a, valid, last_a);
    end
  endtask

  task automatic test_saturation();
    measure(100, 2);
    measure(63, 1);
    measure(64, 1);
    measure(62, 1);
  endtask

  task automatic test_reset_mid_run();
    @(posedge clk);
    #1 start = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (a !== 6'd0 || valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_run: A=%0d valid=%b, expected A=0 valid=0", a, valid);
    end
    #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    vectors++;
    if (a !== 6'd0 || valid !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_idle: A=%0d valid=%b, expected A=0 valid=0", a, valid);
    end
    last_a = 0;
    measure(5, 2);
  endtask

  task automatic test_random();
    int d;
    for (int n = 0; n < 10; n++) begin
      d = int'($urandom_range(0, 75));
      repeat (int'($urandom_range(0, 3))) @(posedge clk);
      measure(d, int'($urandom_range(0, 4)));
    end
  endtask

  task automatic test_back_to_back();
    measure(1, 0);
    measure(6, 0);
    measure(7, 0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    last_a      = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    stop        = 1'b0;
    test_reset();
    test_basic();
    test_same_cycle();
    test_stop_idle();
    test_saturation();
    test_reset_mid_run();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
